// File: rtl/cpu_types_pkg.sv
// Shared MIPS core types: RAM handshake state and the memory arbiter's grant state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE,
    IGRANT,
    DGRANT
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Cache request channels and RAM request port seen by the memory arbiter.
interface memory_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;

  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;

  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/memory_arbiter_perf_counters.sv
// Saturating completion and conflict counters for the memory arbiter (ARB_STATS_EN builds).
module arb_perf_counters
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  icomp,
  input  logic  dcomp,
  input  logic  conflict,
  output word_t igrants,
  output word_t dgrants,
  output word_t conflicts
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      igrants   <= '0;
      dgrants   <= '0;
      conflicts <= '0;
    end else begin
      if (icomp && (igrants != '1))      igrants   <= igrants + 32'd1;
      if (dcomp && (dgrants != '1))      dgrants   <= dgrants + 32'd1;
      if (conflict && (conflicts != '1)) conflicts <= conflicts + 32'd1;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Two-master RAM arbiter (icache/dcache), dcache priority with starvation forcing.
// Define ARB_STATS_EN to add igrants/dgrants/conflicts statistics outputs.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic CLK,
  input  logic nRST,
  memory_arbiter_if.slave arb
`ifdef ARB_STATS_EN
  ,
  output word_t igrants,
  output word_t dgrants,
  output word_t conflicts
`endif
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t       state_q, state_d, pick;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             iforce_q, iforce_d, dforce_q, dforce_d;
  logic             dreq, igo, dgo, icomp, dcomp;
  logic             istarve, dstarve, iforce_now, dforce_now;

  assign dreq    = arb.dREN | arb.dWEN;
  assign igo     = (state_q == IGRANT) && arb.iREN;
  assign dgo     = (state_q == DGRANT) && dreq;
  assign icomp   = igo && (arb.ramstate == ACCESS);
  assign dcomp   = dgo && (arb.ramstate == ACCESS);
  assign istarve = (state_q == DGRANT) && arb.iREN;
  assign dstarve = (state_q == IGRANT) && dreq;
  assign cnt_inc = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);

  // Include this cycle's increment so the limit-reaching completion already hands over.
  assign iforce_now = iforce_q | (istarve && (cnt_inc == CNT_MAX));
  assign dforce_now = dforce_q | (dstarve && (cnt_inc == CNT_MAX));

  always_comb begin
    pick = IDLE;
    if (iforce_now && arb.iREN)  pick = IGRANT;
    else if (dforce_now && dreq) pick = DGRANT;
    else if (dreq)               pick = DGRANT;
    else if (arb.iREN)           pick = IGRANT;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = pick;
      IGRANT:  if (!arb.iREN) state_d = IDLE; else if (icomp) state_d = pick;
      DGRANT:  if (!dreq) state_d = IDLE; else if (dcomp) state_d = pick;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    iforce_d = iforce_q;
    dforce_d = dforce_q;
    if ((state_d == IGRANT) && (state_q != IGRANT)) begin
      cnt_d    = '0;
      iforce_d = 1'b0;
    end else if ((state_d == DGRANT) && (state_q != DGRANT)) begin
      cnt_d    = '0;
      dforce_d = 1'b0;
    end else if (istarve || dstarve) begin
      cnt_d    = cnt_inc;
      iforce_d = iforce_now;
      dforce_d = dforce_now;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      iforce_q <= 1'b0;
      dforce_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      iforce_q <= iforce_d;
      dforce_q <= dforce_d;
    end
  end

  always_comb begin
    arb.ramREN   = 1'b0;
    arb.ramWEN   = 1'b0;
    arb.ramaddr  = '0;
    arb.ramstore = '0;
    if (igo) begin
      arb.ramREN  = 1'b1;
      arb.ramaddr = arb.iaddr;
    end else if (dgo) begin
      arb.ramWEN   = arb.dWEN;
      arb.ramREN   = arb.dREN & ~arb.dWEN;
      arb.ramaddr  = arb.daddr;
      arb.ramstore = arb.dstore;
    end
    arb.iwait = ~icomp;
    arb.iload = icomp ? arb.ramload : '0;
    arb.dwait = ~dcomp;
    arb.dload = (dcomp && !arb.dWEN) ? arb.ramload : '0;
  end

`ifdef ARB_STATS_EN
  arb_perf_counters u_perf (
    .CLK      (CLK),
    .nRST     (nRST),
    .icomp    (icomp),
    .dcomp    (dcomp),
    .conflict (arb.iREN & dreq),
    .igrants  (igrants),
    .dgrants  (dgrants),
    .conflicts(conflicts)
  );
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: RAM model with programmable wait states plus per-cache scoreboards.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  memory_arbiter_if bus ();

`ifdef ARB_STATS_EN
  word_t igrants, dgrants, conflicts;
`endif

  memory_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .arb (bus)
`ifdef ARB_STATS_EN
    ,
    .igrants  (igrants),
    .dgrants  (dgrants),
    .conflicts(conflicts)
`endif
  );

  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    ram_lat = 0;
  word_t iq[$];
  word_t dq[$];
  word_t mem[word_t];

  function automatic word_t ram_rd(word_t a);
    return mem.exists(a) ? mem[a] : (a ^ 32'hA5A5_0000);
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  // RAM model: after ram_lat BUSY cycles it answers ACCESS for one cycle.
  initial begin
    int busy_cnt;
    busy_cnt     = 0;
    bus.ramstate = FREE;
    bus.ramload  = '0;
    forever begin
      @(posedge CLK);
      #2;
      if (bus.ramREN || bus.ramWEN) begin
        if (busy_cnt < ram_lat) begin
          bus.ramstate = BUSY;
          busy_cnt++;
        end else begin
          bus.ramstate = ACCESS;
          busy_cnt     = 0;
          if (bus.ramWEN) begin
            mem[bus.ramaddr] = bus.ramstore;
            bus.ramload      = 32'hBAD0_BAD0;
          end else begin
            bus.ramload = ram_rd(bus.ramaddr);
          end
        end
      end else begin
        bus.ramstate = FREE;
        bus.ramload  = 32'h0BAD_F00D;
        busy_cnt     = 0;
      end
    end
  end

  // Scoreboard: every completion pops its side's queue; a held-off side must show load 0.
  always @(negedge CLK) begin
    if (nRST) begin
      tests++;
      if (!bus.iwait) begin
        if (iq.size() == 0) begin
          fails++;
          $display("FAIL icache_completion: iwait=0 iload=%h, required no completion", bus.iload);
        end else begin
          if (bus.iload !== iq[0]) begin
            fails++;
            $display("FAIL icache_data: iload=%h, required %h", bus.iload, iq[0]);
          end
          void'(iq.pop_front());
        end
      end else if (bus.iload !== 32'h0) begin
        fails++;
        $display("FAIL icache_holdoff: iload=%h, required 0", bus.iload);
      end
      tests++;
      if (!bus.dwait) begin
        if (dq.size() == 0) begin
          fails++;
          $display("FAIL dcache_completion: dwait=0 dload=%h, required no completion", bus.dload);
        end else begin
          if (bus.dload !== dq[0]) begin
            fails++;
            $display("FAIL dcache_data: dload=%h, required %h", bus.dload, dq[0]);
          end
          void'(dq.pop_front());
        end
      end else if (bus.dload !== 32'h0) begin
        fails++;
        $display("FAIL dcache_holdoff: dload=%h, required 0", bus.dload);
      end
    end
  end

  task automatic test_reset();
    nRST = 1'b0;
    bus.iREN = 1'b1; bus.iaddr = 32'h55;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = 32'h66; bus.dstore = 32'h77;
    #1;
    tests++;
    if ({bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN} !== 4'b1100) begin
      fails++;
      $display("FAIL reset_ctrl: iwait,dwait,ramREN,ramWEN=%b, required 1100",
               {bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN});
    end
    tests++;
    if ({bus.iload, bus.dload, bus.ramaddr, bus.ramstore} !== 128'h0) begin
      fails++;
      $display("FAIL reset_data: iload=%h dload=%h ramaddr=%h ramstore=%h, required all 0",
               bus.iload, bus.dload, bus.ramaddr, bus.ramstore);
    end
    bus.iREN = 1'b0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  task automatic test_single_iread();
    int t0, tc, nlow;
    bit got;
    @(posedge CLK); #1;
    ram_lat = 2;
    mem[32'h40] = 32'h8C01_0004;
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    iq.push_back(32'h8C01_0004);
    t0 = cyc; tc = 0; got = 0; nlow = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK); #1;
      if (!bus.iwait) begin got = 1; tc = cyc; break; end
    end
    // Request cycle, grant cycle, two BUSY: completion lands in the fourth cycle.
    tests++;
    if (!got || (tc - t0) != 3) begin
      fails++;
      $display("FAIL iread_latency: completed=%0d after %0d cycles, required 1 after 3", got, tc - t0);
    end
    @(posedge CLK); #1 bus.iREN = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK); #1;
      if (!bus.iwait) nlow++;
    end
    tests++;
    if (nlow != 0 || iq.size() != 0) begin
      fails++;
      $display("FAIL iread_once: extra completions=%0d pending=%0d, required 0 and 0", nlow, iq.size());
    end
  endtask

  task automatic test_simultaneous();
    bit got;
    @(posedge CLK); #1;
    ram_lat = 1;
    bus.iREN = 1'b1; bus.iaddr = 32'h80;
    bus.dREN = 1'b1; bus.daddr = 32'h200;
    iq.push_back(ram_rd(32'h80));
    dq.push_back(ram_rd(32'h200));
    got = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK); #1;
      if (!bus.dwait) begin got = 1; break; end
    end
    tests++;
    if (!got || iq.size() != 1) begin
      fails++;
      $display("FAIL tie_dcache_first: dcache done=%0d icache pending=%0d, required 1 and 1", got, iq.size());
    end
    @(posedge CLK); #1 bus.dREN = 1'b0;
    got = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (!bus.iwait) begin
        got = 1;
        tests++;
        if (bus.ramaddr !== 32'h80 || bus.ramREN !== 1'b1) begin
          fails++;
          $display("FAIL tie_icache_addr: ramaddr=%h ramREN=%b, required 00000080 and 1", bus.ramaddr, bus.ramREN);
        end
        break;
      end
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL tie_icache_next: icache done=0, required 1");
    end
    @(posedge CLK); #1 bus.iREN = 1'b0;
    @(negedge CLK); #1;
    tests++;
    if (iq.size() != 0 || dq.size() != 0) begin
      fails++;
      $display("FAIL tie_drain: pending i=%0d d=%0d, required 0 and 0", iq.size(), dq.size());
    end
  endtask

  task automatic test_back_to_back();
    bit got;
    @(posedge CLK); #1;
    ram_lat = 0;
    bus.dREN = 1'b1; bus.daddr = 32'h100;
    dq.push_back(ram_rd(32'h100));
    got = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK); #1;
      if (!bus.dwait) begin got = 1; break; end
    end
    @(posedge CLK); #1;
    bus.daddr = 32'h104;
    dq.push_back(ram_rd(32'h104));
    @(negedge CLK); #1;
    tests++;
    if (!got || bus.dwait !== 1'b0 || dq.size() != 0) begin
      fails++;
      $display("FAIL b2b_no_bubble: first=%0d second dwait=%b pending=%0d, required 1, 0, 0",
               got, bus.dwait, dq.size());
    end
    @(posedge CLK); #1 bus.dREN = 1'b0;
  endtask

  task automatic test_starvation();
    int t0, tc, nd;
    bit got;
    @(posedge CLK); #1;
    ram_lat = 0;
    bus.dREN = 1'b1; bus.daddr = 32'h200;
    bus.iREN = 1'b1; bus.iaddr = 32'h44;
    iq.push_back(ram_rd(32'h44));
    dq.push_back(ram_rd(32'h200));
    t0 = cyc; tc = 0; nd = 0; got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK); #1;
      if (!bus.dwait) begin nd++; dq.push_back(ram_rd(32'h200)); end
      if (!bus.iwait) begin got = 1; tc = cyc; break; end
    end
    tests++;
    if (!got || nd < 1 || nd > 4) begin
      fails++;
      $display("FAIL starve_bound: icache done=%0d after %0d dcache completions, required 1 after 1..4", got, nd);
    end
    tests++;
    if (!got || (tc - t0) > 5) begin
      fails++;
      $display("FAIL starve_cycles: icache done after %0d cycles, required <= 5", tc - t0);
    end
    @(posedge CLK); #1;
    bus.iREN = 1'b0; bus.dREN = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    tests++;
    if (iq.size() != 0 || dq.size() != 1) begin
      fails++;
      $display("FAIL starve_drain: pending i=%0d d=%0d, required 0 and 1", iq.size(), dq.size());
    end
    dq.delete();
  endtask

  task automatic test_write();
    bit got;
    @(posedge CLK); #1;
    ram_lat = 1;
    bus.dWEN = 1'b1; bus.dREN = 1'b1;
    bus.daddr = 32'h3000; bus.dstore = 32'hDEAD_BEEF;
    dq.push_back(32'h0);
    @(negedge CLK); #1;
    tests++;
    if ({bus.ramREN, bus.ramWEN} !== 2'b00 || bus.ramaddr !== 32'h0) begin
      fails++;
      $display("FAIL idle_quiet: ramREN,ramWEN=%b ramaddr=%h, required 00 and 0", {bus.ramREN, bus.ramWEN}, bus.ramaddr);
    end
    @(negedge CLK); #1;
    tests++;
    if ({bus.ramREN, bus.ramWEN, bus.dwait} !== 3'b011 || bus.ramaddr !== 32'h3000 ||
        bus.ramstore !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL write_drive: ramREN,ramWEN,dwait=%b ramaddr=%h ramstore=%h, required 011 00003000 deadbeef",
               {bus.ramREN, bus.ramWEN, bus.dwait}, bus.ramaddr, bus.ramstore);
    end
    @(negedge CLK); #1;
    tests++;
    if (bus.dwait !== 1'b0) begin
      fails++;
      $display("FAIL write_done: dwait=%b, required 0", bus.dwait);
    end
    @(posedge CLK); #1;
    bus.dWEN = 1'b0; bus.dREN = 1'b0;
    @(posedge CLK); #1;
    bus.dREN = 1'b1; bus.daddr = 32'h3000;
    dq.push_back(32'hDEAD_BEEF);
    got = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK); #1;
      if (!bus.dwait) begin got = 1; break; end
    end
    tests++;
    if (!got || dq.size() != 0) begin
      fails++;
      $display("FAIL write_readback: done=%0d pending=%0d, required 1 and 0", got, dq.size());
    end
    @(posedge CLK); #1 bus.dREN = 1'b0;
  endtask

  task automatic test_drop();
    @(posedge CLK); #1;
    ram_lat = 3;
    bus.iREN = 1'b1; bus.iaddr = 32'h60;
    repeat (2) @(negedge CLK);
    @(posedge CLK); #1 bus.iREN = 1'b0;
    @(negedge CLK); #1;
    tests++;
    if ({bus.ramREN, bus.ramWEN, bus.iwait} !== 3'b001 || bus.ramaddr !== 32'h0) begin
      fails++;
      $display("FAIL drop_quiet: ramREN,ramWEN,iwait=%b ramaddr=%h, required 001 and 0",
               {bus.ramREN, bus.ramWEN, bus.iwait}, bus.ramaddr);
    end
    @(negedge CLK); #1;
    tests++;
    if (dut.state_q !== IDLE) begin
      fails++;
      $display("FAIL drop_idle: state=%0d, required %0d", dut.state_q, IDLE);
    end
  endtask

  task automatic test_reset_mid_grant();
    @(posedge CLK); #1;
    ram_lat = 100;
    bus.dWEN = 1'b1; bus.daddr = 32'h10; bus.dstore = 32'h1234;
    repeat (2) @(negedge CLK);
    #1;
    tests++;
    if (bus.ramWEN !== 1'b1) begin
      fails++;
      $display("FAIL rst_pre_grant: ramWEN=%b, required 1", bus.ramWEN);
    end
    nRST = 1'b0;
    #1;
    tests++;
    if ({bus.ramREN, bus.ramWEN, bus.dwait} !== 3'b001 || dut.state_q !== IDLE) begin
      fails++;
      $display("FAIL rst_async: ramREN,ramWEN,dwait=%b state=%0d, required 001 and %0d",
               {bus.ramREN, bus.ramWEN, bus.dwait}, dut.state_q, IDLE);
    end
    bus.dWEN = 1'b0;
    @(posedge CLK); #1 nRST = 1'b1;
    repeat (3) @(posedge CLK);
  endtask

  initial begin
    fork
      begin
        #200000;
        $display("FAIL global_timeout: simulation still running at 200000, required finish");
        $fatal(1);
      end
    join_none
    test_reset();
    test_single_iread();
    test_simultaneous();
    test_back_to_back();
    test_starvation();
    test_write();
    test_drop();
    test_reset_mid_grant();
    @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
